// File: rtl/port_input_conditioner.sv
// rtl/port_input_conditioner.sv - synchronise, debounce and edge-detect raw input lines
// Each bit gets a sync chain, a consecutive-mismatch counter, registered edge pulses and a sticky event latch.
module port_input_conditioner #(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_raw,
  input  logic [WIDTH-1:0] in_ack,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_rise,
  output logic [WIDTH-1:0] out_fall,
  output logic [WIDTH-1:0] out_event,
  output logic             out_any_event
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {WIDTH{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= in_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A bit is accepted on the edge where its mismatch has persisted DEBOUNCE_CYCLES edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync[i] != out_port[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      out_port  <= {WIDTH{RESET_LEVEL}};
      out_rise  <= '0;
      out_fall  <= '0;
      out_event <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == out_port[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]      <= '0;
          out_port[i] <= sync[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      out_rise  <= accept & sync;
      out_fall  <= accept & ~sync;
      // Set has priority over acknowledge so a press landing on an ack edge is kept.
      out_event <= (accept & sync) | (out_event & ~in_ack);
    end
  end

  assign out_any_event = |out_event;

endmodule

// File: tb/tb_port_input_conditioner.sv
// tb/tb_port_input_conditioner.sv - self-checking bench for port_input_conditioner
// Reference model accepts a level once the last DEB synchronised samples all disagree with it.
module tb_port_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_raw;
  logic [3:0] in_ack;
  logic [3:0] out_port;
  logic [3:0] out_rise;
  logic [3:0] out_fall;
  logic [3:0] out_event;
  logic       out_any_event;

  port_input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .in_ack(in_ack),
    .out_port(out_port), .out_rise(out_rise), .out_fall(out_fall),
    .out_event(out_event), .out_any_event(out_any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_port, m_rise, m_fall, m_event;
  logic [3:0] raw_q[$];

  task automatic model_reset();
    raw_q.delete();
    repeat (SYNC + DEB) raw_q.push_back(4'b0000);
    m_port  = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_event = '0;
  endtask

  // raw_q[k] holds the raw value presented k+1 edges ago; raw_q[SYNC-1] is what the synchroniser shows now.
  task automatic model_edge(input logic [3:0] raw, input logic [3:0] ack);
    logic [3:0] acc;
    for (int b = 0; b < 4; b++) begin
      acc[b] = 1'b1;
      for (int j = SYNC - 1; j < SYNC + DEB - 1; j++) begin
        if (raw_q[j][b] == m_port[b]) acc[b] = 1'b0;
      end
    end
    m_rise  = acc & ~m_port;
    m_fall  = acc & m_port;
    m_event = m_rise | (m_event & ~ack);
    m_port  = m_port ^ acc;
    raw_q.push_front(raw);
    void'(raw_q.pop_back());
  endtask

  task automatic tick(input logic [3:0] raw, input logic [3:0] ack);
    in_raw = raw;
    in_ack = ack;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(raw, ack);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick((i < 7) ? 4'b1111 : 4'b0000, 4'b0000);
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !==
          {m_port, m_rise, m_fall, m_event, |m_event}) begin
        bad++;
        $display("FAIL reset_pre_model t=%0t got=%h exp=%h", $time,
                 {out_port, out_rise, out_fall, out_event, out_any_event},
                 {m_port, m_rise, m_fall, m_event, |m_event});
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({out_port, out_rise, out_fall, out_event, out_any_event} !== 17'd0) begin
      bad++;
      $display("FAIL reset_async got=%h exp=0", {out_port, out_rise, out_fall, out_event, out_any_event});
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111, 4'b0000);
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !== 17'd0) begin
        bad++;
        $display("FAIL reset_hold got=%h exp=0", {out_port, out_rise, out_fall, out_event, out_any_event});
      end
    end
    in_raw = 4'b0000;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 4'b0000);
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !== 17'd0) begin
        bad++;
        $display("FAIL reset_release got=%h exp=0", {out_port, out_rise, out_fall, out_event, out_any_event});
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 9; i++) begin
      tick(4'b0001, 4'b0000);
      total++;
      if (out_port[0] !== (i >= 5) || out_rise[0] !== (i == 5)) begin
        bad++;
        $display("FAIL press_timing edge=E0+%0d port0=%b rise0=%b exp_port0=%b exp_rise0=%b",
                 i, out_port[0], out_rise[0], (i >= 5), (i == 5));
      end
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !==
          {m_port, m_rise, m_fall, m_event, |m_event}) begin
        bad++;
        $display("FAIL press_model t=%0t got=%h exp=%h", $time,
                 {out_port, out_rise, out_fall, out_event, out_any_event},
                 {m_port, m_rise, m_fall, m_event, |m_event});
      end
    end
    total++;
    if (out_port !== 4'b0001 || out_event !== 4'b0001 || out_any_event !== 1'b1) begin
      bad++;
      $display("FAIL press_final port=%b event=%b any=%b exp=0001/0001/1", out_port, out_event, out_any_event);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 11; i++) begin
      tick((i < 3) ? 4'b0101 : 4'b0001, 4'b0000);
      total++;
      if ({out_port[2], out_rise[2], out_fall[2], out_event[2]} !== 4'b0000) begin
        bad++;
        $display("FAIL glitch_bit2 t=%0t got=%b exp=0000", $time,
                 {out_port[2], out_rise[2], out_fall[2], out_event[2]});
      end
    end
  endtask

  task automatic test_bounce();
    int rises, falls, rise_at;
    rises = 0; falls = 0; rise_at = -1;
    for (int i = 0; i < 14; i++) begin
      tick((i < 4 && i % 2 == 1) ? 4'b0001 : 4'b0011, 4'b0000);
      if (out_rise[1]) begin rises++; rise_at = i; end
      if (out_fall[1]) falls++;
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !==
          {m_port, m_rise, m_fall, m_event, |m_event}) begin
        bad++;
        $display("FAIL bounce_model t=%0t got=%h exp=%h", $time,
                 {out_port, out_rise, out_fall, out_event, out_any_event},
                 {m_port, m_rise, m_fall, m_event, |m_event});
      end
    end
    total++;
    if (rises != 1 || rise_at != 9 || falls != 0) begin
      bad++;
      $display("FAIL bounce_pulses rises=%0d at=%0d falls=%0d exp=1/9/0", rises, rise_at, falls);
    end
  endtask

  task automatic test_ack_vs_set();
    logic seen;
    for (int i = 0; i < 8; i++) tick(4'b1011, 4'b0000);
    total++;
    if (out_event[3] !== 1'b1) begin
      bad++;
      $display("FAIL ack_set_initial event3=%b exp=1", out_event[3]);
    end
    tick(4'b1011, 4'b1000);
    total++;
    if (out_event[3] !== 1'b0) begin
      bad++;
      $display("FAIL ack_clear event3=%b exp=0", out_event[3]);
    end
    for (int i = 0; i < 8; i++) tick(4'b0011, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b1011, 4'b1000);
      if (out_rise[3]) begin
        seen = 1'b1;
        total++;
        if (out_event[3] !== 1'b1) begin
          bad++;
          $display("FAIL ack_set_wins event3=%b exp=1", out_event[3]);
        end
      end
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !==
          {m_port, m_rise, m_fall, m_event, |m_event}) begin
        bad++;
        $display("FAIL ack_model t=%0t got=%h exp=%h", $time,
                 {out_port, out_rise, out_fall, out_event, out_any_event},
                 {m_port, m_rise, m_fall, m_event, |m_event});
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_rise_timeout seen=0 exp=1");
    end
  endtask

  task automatic test_multi();
    int nr, nf;
    nr = 0; nf = 0;
    for (int i = 0; i < 8; i++) tick(4'b0000, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      tick(4'b1010, 4'b0000);
      if (out_rise == 4'b1010) nr++;
      else if (out_rise != 4'b0000) nr += 100;
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 4'b0000);
      if (out_fall == 4'b1010) nf++;
      else if (out_fall != 4'b0000) nf += 100;
      total++;
      if (out_event !== 4'b1010) begin
        bad++;
        $display("FAIL multi_event_hold event=%b exp=1010", out_event);
      end
    end
    total++;
    if (nr != 1 || nf != 1) begin
      bad++;
      $display("FAIL multi_pulses rise_count=%0d fall_count=%0d exp=1/1", nr, nf);
    end
    tick(4'b0000, 4'b1111);
    total++;
    if (out_event !== 4'b0000 || out_any_event !== 1'b0) begin
      bad++;
      $display("FAIL multi_ack event=%b any=%b exp=0000/0", out_event, out_any_event);
    end
  endtask

  task automatic test_random();
    logic [3:0] raw, ack;
    raw = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) raw[b] = ~raw[b];
        ack[b] = ($urandom_range(3) == 0);
      end
      tick(raw, ack);
      total++;
      if ({out_port, out_rise, out_fall, out_event, out_any_event} !==
          {m_port, m_rise, m_fall, m_event, |m_event}) begin
        bad++;
        $display("FAIL random_model t=%0t got=%h exp=%h", $time,
                 {out_port, out_rise, out_fall, out_event, out_any_event},
                 {m_port, m_rise, m_fall, m_event, |m_event});
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    in_raw = 4'b0000;
    in_ack = 4'b0000;
    model_reset();
    for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_ack_vs_set();
    test_multi();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
